// File: rtl/rf_wr_arbiter.sv
// Write-port controller for the 32x32 register file.
// Shares the single write port between core writeback (wb), the load/MDU
// unit (ld) and the debug module (dbg), and optionally zeroes x1..x31
// after every reset before normal traffic is admitted.
module rf_wr_arbiter #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_rd,
    input  logic [31:0] dbg_data,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic        init_busy,
    output logic [1:0]  grant_id
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam logic [1:0] GNT_WB   = 2'd0;
    localparam logic [1:0] GNT_LD   = 2'd1;
    localparam logic [1:0] GNT_DBG  = 2'd2;
    localparam logic [1:0] GNT_NONE = 2'd3;
    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [4:0] LAST_IDX = 5'd31;

    state_t      state_q, state_d, mode;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  ld_cnt_q, ld_cnt_d;
    logic [3:0]  dbg_cnt_q, dbg_cnt_d;
    logic        ld_urgent, dbg_urgent;

    assign ld_urgent  = ld_valid  && (ld_cnt_q  == LIMIT);
    assign dbg_urgent = dbg_valid && (dbg_cnt_q == LIMIT);

    // State, sweep index and starvation counters; reset is synchronous.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update together
        // from the values present before the edge, independent of order.
        if (!rst_n) begin
            state_q   <= ST_RESET;
            idx_q     <= 5'd1;
            ld_cnt_q  <= '0;
            dbg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ld_cnt_q  <= ld_cnt_d;
            dbg_cnt_q <= dbg_cnt_d;
        end
    end

    // RESET with rst_n released already behaves as the first cycle of the
    // mode it is leaving for, so sweep index 1 (or the first grant) lands in
    // cycle 1.
    always_comb begin
        mode = state_q;
        if (state_q == ST_RESET) begin
            mode = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        end
    end

    // Next state, sweep writes and fixed-priority arbitration.
    always_comb begin
        // NOTE: every output gets a default first; a path that forgets one
        // would otherwise infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        wb_ready  = 1'b0;
        ld_ready  = 1'b0;
        dbg_ready = 1'b0;
        rf_we     = 1'b0;
        rf_rd     = '0;
        rf_wd     = '0;
        grant_id  = GNT_NONE;
        init_busy = 1'b0;

        if (!rst_n) begin
            // Outputs are forced idle for the whole reset, even before the
            // clearing edge arrives.
            init_busy = CLEAR_ON_RESET;
        end else begin
            case (mode)
                ST_CLEAR: begin
                    init_busy = 1'b1;
                    rf_we     = 1'b1;
                    rf_rd     = idx_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_CLEAR;
                        idx_d   = idx_q + 5'd1;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                    if (ld_urgent) begin
                        grant_id = GNT_LD;
                    end else if (dbg_urgent) begin
                        grant_id = GNT_DBG;
                    end else if (wb_valid) begin
                        grant_id = GNT_WB;
                    end else if (ld_valid) begin
                        grant_id = GNT_LD;
                    end else if (dbg_valid) begin
                        grant_id = GNT_DBG;
                    end

                    case (grant_id)
                        GNT_WB: begin
                            wb_ready = 1'b1;
                            rf_rd    = wb_rd;
                            rf_wd    = wb_data;
                        end
                        GNT_LD: begin
                            ld_ready = 1'b1;
                            rf_rd    = ld_rd;
                            rf_wd    = ld_data;
                        end
                        GNT_DBG: begin
                            dbg_ready = 1'b1;
                            rf_rd     = dbg_rd;
                            rf_wd     = dbg_data;
                        end
                        default: ;
                    endcase

                    // x0 is hardwired: accept the handshake, drop the write.
                    rf_we = (grant_id != GNT_NONE) && (rf_rd != 5'd0);
                end
                default: ;
            endcase
        end
    end

    // Starvation counters: count blocked cycles, saturate at the limit,
    // clear on grant or when the request goes away.
    always_comb begin
        ld_cnt_d  = '0;
        dbg_cnt_d = '0;
        if (ld_valid && !ld_ready) begin
            ld_cnt_d = (ld_cnt_q >= LIMIT) ? LIMIT : ld_cnt_q + 4'd1;
        end
        if (dbg_valid && !dbg_ready) begin
            dbg_cnt_d = (dbg_cnt_q >= LIMIT) ? LIMIT : dbg_cnt_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed reset/sweep, priority,
// x0, idle and starvation scenarios plus randomized traffic, all compared
// through a scoreboard fed by a request-level reference model.
module tb_rf_wr_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, ld_valid, dbg_valid;
    logic        wb_ready, ld_ready, dbg_ready;
    logic [4:0]  wb_rd, ld_rd, dbg_rd;
    logic [31:0] wb_data, ld_data, dbg_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        init_busy;
    logic [1:0]  grant_id;

    rf_wr_arbiter #(
        .CLEAR_ON_RESET(1'b1),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_rd    (ld_rd),
        .ld_data  (ld_data),
        .dbg_valid(dbg_valid),
        .dbg_ready(dbg_ready),
        .dbg_rd   (dbg_rd),
        .dbg_data (dbg_data),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_wd    (rf_wd),
        .init_busy(init_busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [31:0] d;
    } req_t;

    localparam logic [42:0] IDLE_VEC = {1'b0, 5'd0, 32'd0, 2'd3, 3'b000};

    int          checks_total  = 0;
    int          checks_passed = 0;
    logic [42:0] exp_q[$];
    logic [31:0] rf_mem[32];
    logic [31:0] exp_rf[32];
    req_t        req[3];
    int          wait_c[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [42:0] out_vec();
        return {rf_we, rf_rd, rf_wd, grant_id, dbg_ready, ld_ready, wb_ready};
    endfunction

    // Reference rule: an ld/dbg request that has been blocked for at least
    // LIMIT cycles is urgent; otherwise wb > ld > dbg.
    function automatic int model_grant();
        if (req[1].v && wait_c[1] >= LIMIT) return 1;
        if (req[2].v && wait_c[2] >= LIMIT) return 2;
        if (req[0].v) return 0;
        if (req[1].v) return 1;
        if (req[2].v) return 2;
        return 3;
    endfunction

    task automatic set_req(input int r, input logic [4:0] rd, input logic [31:0] d);
        req[r].v  = 1'b1;
        req[r].rd = rd;
        req[r].d  = d;
    endtask

    // One RUN cycle: drive pending requests, predict, push expectation,
    // then leave the caller at the falling edge of that cycle.
    task automatic drive_cycle();
        int          g;
        logic [42:0] e;
        @(posedge clk);
        #1;
        wb_valid  = req[0].v; wb_rd  = req[0].rd; wb_data  = req[0].d;
        ld_valid  = req[1].v; ld_rd  = req[1].rd; ld_data  = req[1].d;
        dbg_valid = req[2].v; dbg_rd = req[2].rd; dbg_data = req[2].d;
        g = model_grant();
        if (g != 3) begin
            e = {req[g].rd != 5'd0, req[g].rd, req[g].d, 2'(g), 3'(1 << g)};
            exp_q.push_back(e);
            if (req[g].rd != 5'd0) exp_rf[req[g].rd] = req[g].d;
        end
        for (int r = 1; r < 3; r++) begin
            wait_c[r] = (req[r].v && r != g) ? wait_c[r] + 1 : 0;
        end
        if (g != 3) req[g].v = 1'b0;
        @(negedge clk);
    endtask

    // Register-file stand-in: powers up with garbage except x0.
    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : $urandom;
        forever begin
            @(posedge clk);
            if (rf_we === 1'b1) rf_mem[rf_rd] = rf_wd;
        end
    end

    // Monitor: whenever the DUT presents a grant or write in RUN, pop and compare.
    initial begin
        logic [42:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && init_busy === 1'b0 && out_vec() !== IDLE_VEC) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_grant", 64'(out_vec()), 64'(IDLE_VEC));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_grant", 64'(out_vec()), 64'(e));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ld_cycle;
        int dbg_cycle;
        int nz;
        int prob[3];

        prob[0] = 60; prob[1] = 35; prob[2] = 30;
        rst_n = 1'b0;
        wb_valid = 1'b0; ld_valid = 1'b0; dbg_valid = 1'b0;
        wb_rd = '0; ld_rd = '0; dbg_rd = '0;
        wb_data = '0; ld_data = '0; dbg_data = '0;
        for (int r = 0; r < 3; r++) begin
            req[r].v = 1'b0; req[r].rd = '0; req[r].d = '0; wait_c[r] = 0;
        end
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;

        // Reset outputs.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {out_vec(), init_busy}, {IDLE_VEC, 1'b1});

        // Partial sweep, then a one-cycle reset at index 10.
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("sweep_first", {out_vec(), init_busy},
                  {1'b1, 5'(c), 32'd0, 2'd3, 3'b000, 1'b1});
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midsweep_reset_outputs", {out_vec(), init_busy}, {IDLE_VEC, 1'b1});
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            check("sweep_restart", {out_vec(), init_busy},
                  {1'b1, 5'(c), 32'd0, 2'd3, 3'b000, 1'b1});
        end

        // Cycle 32: all three requesters at once.
        set_req(0, 5'd5, 32'hAAAA_0000);
        set_req(1, 5'd6, 32'h1111_1111);
        set_req(2, 5'd7, 32'h2222_2222);
        drive_cycle();
        check("init_busy_done", init_busy, 0);
        nz = 0;
        for (int i = 1; i < 32; i++) if (rf_mem[i] !== 32'd0) nz++;
        check("sweep_zeroed_regs", nz, 0);
        drive_cycle();
        check("x5_after_wb", rf_mem[5], 32'hAAAA_0000);
        drive_cycle();
        check("x6_after_ld", rf_mem[6], 32'h1111_1111);
        drive_cycle();
        check("x7_after_dbg", rf_mem[7], 32'h2222_2222);

        // Write to x0 is accepted but discarded.
        set_req(0, 5'd0, 32'hDEAD_BEEF);
        drive_cycle();
        check("x0_accept", {rf_we, wb_ready}, {1'b0, 1'b1});
        drive_cycle();
        check("x0_reads_zero", rf_mem[0], 0);

        // Idle.
        for (int k = 0; k < 3; k++) begin
            drive_cycle();
            check("idle_outputs", out_vec(), IDLE_VEC);
        end

        // ld alone against continuous wb traffic.
        ld_cycle = -1;
        for (int k = 0; k < 12; k++) begin
            if (!req[0].v) set_req(0, 5'($urandom_range(1, 31)), $urandom);
            if (k == 0) set_req(1, 5'd9, 32'h0BAD_F00D);
            drive_cycle();
            if (ld_ready === 1'b1 && ld_cycle < 0) ld_cycle = k;
        end
        check("starve_ld_wait", ld_cycle, LIMIT);

        // ld and dbg together against continuous wb traffic.
        ld_cycle  = -1;
        dbg_cycle = -1;
        for (int k = 0; k < 12; k++) begin
            if (!req[0].v) set_req(0, 5'($urandom_range(1, 31)), $urandom);
            if (k == 0) begin
                set_req(1, 5'd10, 32'h1234_5678);
                set_req(2, 5'd11, 32'h8765_4321);
            end
            drive_cycle();
            if (ld_ready === 1'b1 && ld_cycle < 0) ld_cycle = k;
            if (dbg_ready === 1'b1 && dbg_cycle < 0) dbg_cycle = k;
        end
        check("starve_ld_first", ld_cycle, LIMIT);
        check("starve_dbg_next", dbg_cycle, LIMIT + 1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 3; r++) begin
                if (!req[r].v && $urandom_range(0, 99) < prob[r]) begin
                    set_req(r, 5'($urandom_range(0, 31)), $urandom);
                end
            end
            drive_cycle();
        end
        for (int n = 0; n < 20; n++) drive_cycle();
        drive_cycle();

        check("sb_drain", exp_q.size(), 0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("rf_final_x%0d", i), rf_mem[i], exp_rf[i]);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Write-port controller for the 32x32 register file. It shares the file's single synchronous write port among three requesters: core writeback, the multi-cycle load/MDU unit, and the debug module. The register file does not clear its contents on reset, so this block can also run a post-reset sweep that writes zero to x1..x31 before normal traffic is allowed. It sits between the writeback stage and the register-file write pins (we/rd/wd).

## Interface
- CLEAR_ON_RESET, 1: when 1, run the zeroing sweep after every reset; when 0, enter RUN immediately.
- STARVE_LIMIT, 4: number of consecutive blocked cycles after which req1 or req2 becomes urgent (legal range 1..15).
- clk  in  1  clock; all state updates on the posedge.
- rst_n  in  1  reset, synchronous, active-low.
- wb_valid / wb_ready  in / out  1  handshake for req0 (core writeback).
- wb_rd / wb_data  in  5 / 32  req0 destination index and data.
- ld_valid / ld_ready  in / out  1  handshake for req1 (load/MDU).
- ld_rd / ld_data  in  5 / 32  req1 destination index and data.
- dbg_valid / dbg_ready  in / out  1  handshake for req2 (debug).
- dbg_rd / dbg_data  in  5 / 32  req2 destination index and data.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write index.
- rf_wd  out  32  register-file write data.
- init_busy  out  1  high while the reset sweep is pending or running.
- grant_id  out  2  granted requester this cycle: 0=wb, 1=ld, 2=dbg, 3=none or sweep.

## Operation
- States are RESET, CLEAR, and RUN. While rst_n=0 the block is held in RESET. On the first cycle with rst_n=1 it moves to CLEAR if CLEAR_ON_RESET=1, otherwise to RUN.
- CLEAR:
  - A 5-bit index runs from 1 to 31, one step per cycle.
  - Outputs each cycle: rf_we=1, rf_rd=index, rf_wd=0, grant_id=3, and all readies 0.
  - After index 31 the block enters RUN. The index does not wrap.
- RUN:
  - A transfer happens when valid and ready are both 1 in the same cycle. At most one ready is high per cycle.
  - Priority order: urgent ld, then urgent dbg, then wb, then ld, then dbg.
  - The granted request drives rf_rd and rf_wd directly.
  - rf_we=1 only if the granted rd is not 0. A write to x0 is still accepted (ready=1) but is discarded.
  - With no valid requester: rf_we=0, rf_rd=0, rf_wd=0, grant_id=3.
- Starvation counters (ld, dbg):
  - Each is 4 bits wide.
  - Increments by 1 on each cycle its valid=1 and it is not granted.
  - Clears to 0 on a grant or when its valid=0.
  - Saturates at STARVE_LIMIT.
  - The requester is urgent while its count equals STARVE_LIMIT.
  - wb has no counter.
- Requester rules:
  - Once valid is raised, rd and data must stay stable until the handshake completes.
  - valid must not drop before the handshake.
  - ready may depend combinationally on valid.
- If rst_n=0 arrives mid-sweep or mid-traffic, state, index, and counters are cleared at that posedge. The sweep then restarts from x1. Nothing in flight is retained.

## Timing
- While rst_n=0, all outputs hold these values: readies 0, rf_we=0, rf_rd=0, rf_wd=0, grant_id=3, and init_busy=CLEAR_ON_RESET.
- Arbitration is combinational. The register file captures the write at the posedge that closes the handshake cycle, so the write is visible on its read ports in the next cycle (1-cycle latency).
- With CLEAR_ON_RESET=1:
  - The sweep occupies cycles 1..31 after reset release (cycle 1 is the first cycle with rst_n=1).
  - init_busy falls at the start of cycle 32, and the first grant is possible in cycle 32.
- With CLEAR_ON_RESET=0, init_busy=0 and grants are possible from cycle 1.
- Worst-case wait under continuous wb traffic:
  - ld waits STARVE_LIMIT cycles and is granted on the next cycle.
  - dbg waits at most STARVE_LIMIT cycles plus one ld urgent grant.

## Test plan
- Reset sweep: CLEAR_ON_RESET=1, release reset, read back the register file -> rf_we=1 with rf_rd=1..31 on cycles 1..31, all registers read 0, init_busy=0 in cycle 32.
- Priority: in one cycle wb(rd=5, 0xAAAA0000), ld(rd=6, 0x11111111), dbg(rd=7, 0x22222222) all valid -> wb_ready=1 only, grant_id=0, x5 reads 0xAAAA0000 in the next cycle; ld is granted in the following cycle.
- Starvation: STARVE_LIMIT=4, wb valid every cycle, ld valid from cycle t -> ld_ready=1 in cycle t+4, grant_id=1, wb blocked that cycle.
- x0 write: wb(rd=0, 0xDEADBEEF) valid -> wb_ready=1, rf_we=0, x0 reads 0.
- Reset mid-sweep: assert rst_n=0 at sweep index 10 for 1 cycle -> sweep restarts at rf_rd=1, init_busy stays 1, 31 more sweep cycles follow.
- Idle: no valids in RUN -> rf_we=0, grant_id=3, all starvation counts 0.
